// File: rtl/execute_muldiv_pkg.sv
// ---------------------------------------------------------------------------
// muldiv_pkg
// Shared definitions for the execute-stage RV32M multiply/divide unit:
//   - muldiv_op_e : funct3 encodings of the M-extension ops
//   - state_e     : control FSM states
//   - DIV0_QUOT   : quotient returned for a divide by zero
//   - INT_MIN     : most negative 32-bit value (signed-overflow operand/result)
//   - neg_if      : conditional two's-complement negate
// ---------------------------------------------------------------------------
package muldiv_pkg;

    typedef enum logic [2:0] {
        MUL    = 3'b000,
        MULH   = 3'b001,
        MULHSU = 3'b010,
        MULHU  = 3'b011,
        DIV    = 3'b100,
        DIVU   = 3'b101,
        REM    = 3'b110,
        REMU   = 3'b111
    } muldiv_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN   = 32'h8000_0000;

    function automatic logic [31:0] neg_if(input logic [31:0] v, input logic n);
        return n ? (32'd0 - v) : v;
    endfunction

endpackage

// File: rtl/execute_muldiv_if.sv
// ---------------------------------------------------------------------------
// execute_muldiv_if
// Execute-stage connection between the pipeline and the mul/div unit.
//   flush        : abort the operation in flight
//   valid_e      : execute-stage instruction valid
//   mul_sel_e    : execute-stage instruction is M-extension
//   funct3_e     : instr_e[14:12], op select
//   op_a, op_b   : forwarded rs1 / rs2
//   busy         : combinational stall request to the hazard unit
//   result       : registered result, valid while result_valid
//   result_valid : one-cycle result strobe
// master = pipeline side, slave = mul/div unit.
// ---------------------------------------------------------------------------
interface execute_muldiv_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  flush;
    logic                  valid_e;
    logic                  mul_sel_e;
    logic [2:0]            funct3_e;
    logic [DATA_WIDTH-1:0] op_a;
    logic [DATA_WIDTH-1:0] op_b;
    logic                  busy;
    logic [DATA_WIDTH-1:0] result;
    logic                  result_valid;

    modport master (
        output flush, valid_e, mul_sel_e, funct3_e, op_a, op_b,
        input  busy, result, result_valid
    );

    modport slave (
        input  flush, valid_e, mul_sel_e, funct3_e, op_a, op_b,
        output busy, result, result_valid
    );
endinterface

// File: rtl/execute_muldiv_datapath.sv
// ---------------------------------------------------------------------------
// muldiv_datapath
// Iterative shift-add multiplier / restoring divider sharing one 64-bit
// accumulator {hi, lo} and a 32-bit operand register m.
//   clk, rst   : clock, synchronous active-high reset
//   start      : load magnitudes (lo <= a_mag, m <= b_mag, hi <= 0), cnt <= 0
//   step       : perform one iteration
//   finish     : abandon the operation (counter back to 0)
//   is_div     : operation type captured at start
//   a_mag      : multiplier / dividend magnitude
//   b_mag      : multiplicand / divisor magnitude
//   last       : the current step is the 32nd
//   hi_next    : accumulator high half after the current step (remainder)
//   lo_next    : accumulator low half after the current step (quotient)
// ---------------------------------------------------------------------------
module muldiv_datapath #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  step,
    input  logic                  finish,
    input  logic                  is_div,
    input  logic [DATA_WIDTH-1:0] a_mag,
    input  logic [DATA_WIDTH-1:0] b_mag,
    output logic                  last,
    output logic [DATA_WIDTH-1:0] hi_next,
    output logic [DATA_WIDTH-1:0] lo_next
);

    logic [DATA_WIDTH-1:0] hi, lo, m;
    logic [CNT_WIDTH-1:0]  cnt;
    logic                  div_q;

    logic [DATA_WIDTH:0]   add_sum;
    logic [DATA_WIDTH:0]   shifted;
    logic [DATA_WIDTH:0]   trial;
    logic                  ge;

    always_comb begin
        // Multiply: {hi,lo} holds the partial product with the remaining
        // multiplier bits in lo; add m when lo[0] is set, then shift right.
        add_sum = {1'b0, hi} + (lo[0] ? {1'b0, m} : '0);
        // Divide: shift the next dividend bit from lo into the remainder,
        // subtract the divisor in 33 bits, keep it if no borrow.
        shifted = {hi, lo[DATA_WIDTH-1]};
        trial   = shifted - {1'b0, m};
        ge      = (shifted >= {1'b0, m});
        if (div_q) begin
            hi_next = ge ? trial[DATA_WIDTH-1:0] : shifted[DATA_WIDTH-1:0];
            lo_next = {lo[DATA_WIDTH-2:0], ge};
        end else begin
            hi_next = add_sum[DATA_WIDTH:1];
            lo_next = {add_sum[0], lo[DATA_WIDTH-1:1]};
        end
        last = (cnt == '1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hi    <= '0;
            lo    <= '0;
            m     <= '0;
            cnt   <= '0;
            div_q <= 1'b0;
        end else if (start) begin
            hi    <= '0;
            lo    <= a_mag;
            m     <= b_mag;
            cnt   <= '0;
            div_q <= is_div;
        end else if (finish) begin
            cnt   <= '0;
        end else if (step) begin
            hi    <= hi_next;
            lo    <= lo_next;
            cnt   <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/execute_muldiv.sv
// ---------------------------------------------------------------------------
// execute_muldiv
// Iterative RV32M multiply/divide unit in the execute stage.
//   clk : clock
//   rst : synchronous, active-high reset
//   mdu : execute_muldiv_if.slave (flush, valid_e, mul_sel_e, funct3_e,
//         op_a, op_b in; busy, result, result_valid out)
// Normal ops take 32 iterations (busy for 33 cycles, result one cycle later);
// divide-by-zero and signed overflow complete in one cycle.
// ---------------------------------------------------------------------------
module execute_muldiv
    import muldiv_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 5
) (
    input  logic               clk,
    input  logic               rst,
    execute_muldiv_if.slave    mdu
);

    state_e                  state;
    muldiv_op_e              op, op_q;
    logic                    neg_q;
    logic                    result_valid_q;
    logic [DATA_WIDTH-1:0]   result_q;

    logic                    start, is_div_e, a_sgn, b_sgn, a_neg, b_neg, neg_e;
    logic                    fast, last;
    logic [DATA_WIDTH-1:0]   a_mag, b_mag, fast_res;
    logic [DATA_WIDTH-1:0]   hi_next, lo_next, quot_s, rem_s, final_res;
    logic [2*DATA_WIDTH-1:0] prod, prod_s;

    always_comb begin
        op       = muldiv_op_e'(mdu.funct3_e);
        start    = mdu.valid_e & mdu.mul_sel_e & (state == IDLE) & ~mdu.flush;
        is_div_e = mdu.funct3_e[2];
        a_sgn    = (op == MULH) | (op == MULHSU) | (op == DIV) | (op == REM);
        b_sgn    = (op == MULH) | (op == DIV) | (op == REM);
        a_neg    = a_sgn & mdu.op_a[DATA_WIDTH-1];
        b_neg    = b_sgn & mdu.op_b[DATA_WIDTH-1];
        // Remainder follows the dividend; product and quotient use the XOR.
        neg_e    = (op == REM) ? a_neg : (a_neg ^ b_neg);
        a_mag    = neg_if(mdu.op_a, a_neg);
        b_mag    = neg_if(mdu.op_b, b_neg);

        fast     = is_div_e & ((mdu.op_b == '0) |
                               (b_sgn & (mdu.op_a == INT_MIN) & (mdu.op_b == '1)));
        if (mdu.op_b == '0)
            fast_res = mdu.funct3_e[1] ? mdu.op_a : DIV0_QUOT;
        else
            fast_res = mdu.funct3_e[1] ? '0 : INT_MIN;

        // Final result is formed from the post-step accumulator so it can be
        // registered on the same edge as the last iteration.
        prod     = {hi_next, lo_next};
        prod_s   = neg_q ? ('0 - prod) : prod;
        quot_s   = neg_if(lo_next, neg_q);
        rem_s    = neg_if(hi_next, neg_q);
        case (op_q)
            MUL:                 final_res = prod_s[DATA_WIDTH-1:0];
            MULH, MULHSU, MULHU: final_res = prod_s[2*DATA_WIDTH-1:DATA_WIDTH];
            DIV, DIVU:           final_res = quot_s;
            REM, REMU:           final_res = rem_s;
            default:             final_res = '0;
        endcase
    end

    muldiv_datapath #(
        .DATA_WIDTH (DATA_WIDTH),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_datapath (
        .clk     (clk),
        .rst     (rst),
        .start   (start & ~fast),
        .step    (state == BUSY),
        .finish  (mdu.flush),
        .is_div  (is_div_e),
        .a_mag   (a_mag),
        .b_mag   (b_mag),
        .last    (last),
        .hi_next (hi_next),
        .lo_next (lo_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            op_q           <= MUL;
            neg_q          <= 1'b0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
        end else begin
            result_valid_q <= 1'b0;
            if (mdu.flush) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            op_q  <= op;
                            neg_q <= neg_e;
                            if (fast) begin
                                result_q       <= fast_res;
                                result_valid_q <= 1'b1;
                                state          <= DONE;
                            end else begin
                                state <= BUSY;
                            end
                        end
                    end
                    BUSY: begin
                        if (last) begin
                            result_q       <= final_res;
                            result_valid_q <= 1'b1;
                            state          <= DONE;
                        end
                    end
                    // Instruction is still presented here; leave without
                    // restarting so the pipeline can advance this edge.
                    DONE:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign mdu.busy         = (start | (state == BUSY)) & ~mdu.flush;
    assign mdu.result       = result_q;
    assign mdu.result_valid = result_valid_q;

endmodule

// File: tb/tb_execute_muldiv.sv
module tb_execute_muldiv;

    logic clk;
    logic rst;
    int   cyc;
    int   tests;
    int   fails;

    typedef struct {
        logic [31:0] res;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];

    execute_muldiv_if #(.DATA_WIDTH(32)) mdu ();

    execute_muldiv #(
        .DATA_WIDTH (32),
        .CNT_WIDTH  (5)
    ) dut (
        .clk (clk),
        .rst (rst),
        .mdu (mdu)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model straight from the RV32M rules.
    function automatic void model(input logic [2:0] f3, input logic [31:0] a,
                                  input logic [31:0] b,
                                  output logic [31:0] r, output int lat);
        logic [63:0] ea, eb, p;
        int sa, sb;
        lat = 33;
        sa  = $signed(a);
        sb  = $signed(b);
        r   = '0;
        case (f3)
            3'd0, 3'd1, 3'd2, 3'd3: begin
                ea = (f3 == 3'd1 || f3 == 3'd2) ? {{32{a[31]}}, a} : {32'd0, a};
                eb = (f3 == 3'd1) ? {{32{b[31]}}, b} : {32'd0, b};
                p  = ea * eb;
                r  = (f3 == 3'd0) ? p[31:0] : p[63:32];
            end
            3'd4: begin
                if (b == 0) begin r = 32'hFFFFFFFF; lat = 1; end
                else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin r = a; lat = 1; end
                else r = 32'(sa / sb);
            end
            3'd5: begin
                if (b == 0) begin r = 32'hFFFFFFFF; lat = 1; end
                else r = a / b;
            end
            3'd6: begin
                if (b == 0) begin r = a; lat = 1; end
                else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin r = 0; lat = 1; end
                else r = 32'(sa % sb);
            end
            default: begin
                if (b == 0) begin r = a; lat = 1; end
                else r = a % b;
            end
        endcase
    endfunction

    // Presents one M instruction, holds it through DONE, checks busy length.
    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] er;
        int lat;
        int nb;
        exp_t e;
        model(f3, a, b, er, lat);
        @(posedge clk); #1;
        mdu.flush     = 1'b0;
        mdu.valid_e   = 1'b1;
        mdu.mul_sel_e = 1'b1;
        mdu.funct3_e  = f3;
        mdu.op_a      = a;
        mdu.op_b      = b;
        e.res = er;
        e.cyc = cyc + lat;
        exp_q.push_back(e);
        nb = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (mdu.busy) nb++;
            else break;
        end
        chk($sformatf("busy_cycles f3=%0d", f3), 32'(nb), 32'(lat));
    endtask

    task automatic idle_inputs();
        @(posedge clk); #1;
        mdu.valid_e   = 1'b0;
        mdu.mul_sel_e = 1'b0;
        mdu.flush     = 1'b0;
    endtask

    // Monitor: every result_valid must match the oldest outstanding op.
    always @(negedge clk) begin
        if (!rst && mdu.result_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_result_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("result", mdu.result, e.res);
                chk("result_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'hFFFFFFFF;
            2:       return 32'h80000000;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int t0;
        tests = 0;
        fails = 0;
        rst = 1'b1;
        mdu.flush = 1'b0; mdu.valid_e = 1'b0; mdu.mul_sel_e = 1'b0;
        mdu.funct3_e = '0; mdu.op_a = '0; mdu.op_b = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_busy", 32'(mdu.busy), 32'd0);
        chk("reset_result_valid", 32'(mdu.result_valid), 32'd0);
        chk("reset_result", mdu.result, 32'd0);

        // Non-M instruction: no action.
        @(posedge clk); #1;
        mdu.valid_e = 1'b1; mdu.mul_sel_e = 1'b0; mdu.funct3_e = 3'd0;
        mdu.op_a = 32'd5; mdu.op_b = 32'd6;
        @(negedge clk);
        chk("non_m_busy", 32'(mdu.busy), 32'd0);
        @(posedge clk); #1;
        mdu.valid_e = 1'b0; mdu.mul_sel_e = 1'b1;
        @(negedge clk);
        chk("invalid_busy", 32'(mdu.busy), 32'd0);
        idle_inputs();

        // Directed cases, issued back to back.
        issue(3'd0, 32'd7, 32'hFFFFFFFD);
        issue(3'd1, 32'h80000000, 32'h80000000);
        issue(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF);
        issue(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF);
        issue(3'd4, 32'hFFFFFFF9, 32'd2);
        issue(3'd6, 32'hFFFFFFF9, 32'd2);
        issue(3'd5, 32'd100, 32'd7);
        issue(3'd7, 32'd100, 32'd7);
        issue(3'd5, 32'd5, 32'd0);
        issue(3'd7, 32'd5, 32'd0);
        issue(3'd4, 32'h80000000, 32'hFFFFFFFF);
        issue(3'd6, 32'h80000000, 32'hFFFFFFFF);
        idle_inputs();

        // Flush at T+10 of a DIV, then MUL 3 x 4 in the following cycle.
        @(posedge clk); #1;
        mdu.valid_e = 1'b1; mdu.mul_sel_e = 1'b1; mdu.funct3_e = 3'd4;
        mdu.op_a = 32'd1000; mdu.op_b = 32'd3;
        t0 = cyc;
        repeat (10) @(posedge clk);
        #1 mdu.flush = 1'b1;
        chk("flush_at_t10", 32'(cyc - t0), 32'd10);
        @(negedge clk);
        chk("flush_busy", 32'(mdu.busy), 32'd0);
        issue(3'd0, 32'd3, 32'd4);
        idle_inputs();

        // Reset in the middle of an operation.
        @(posedge clk); #1;
        mdu.valid_e = 1'b1; mdu.mul_sel_e = 1'b1; mdu.funct3_e = 3'd3;
        mdu.op_a = 32'h12345678; mdu.op_b = 32'h9ABCDEF0;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        mdu.valid_e = 1'b0;
        @(negedge clk);
        chk("rst_busy", 32'(mdu.busy), 32'd0);
        chk("rst_result_valid", 32'(mdu.result_valid), 32'd0);
        chk("rst_result", mdu.result, 32'd0);
        issue(3'd1, 32'hFFFFFFFE, 32'd9);
        idle_inputs();

        // Randomized ops, with occasional bubbles between them.
        for (int n = 0; n < 40; n++) begin
            issue(3'($urandom_range(0, 7)), pick_operand(), pick_operand());
            if ($urandom_range(0, 3) == 0) idle_inputs();
        end
        idle_inputs();

        repeat (5) @(posedge clk);
        chk("outstanding_results", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/execute_muldiv.md
# execute_muldiv

Iterative RV32M multiply/divide unit in the execute stage, directly downstream of the decode/execute pipeline register. It consumes the execute-stage valid, mul-select, funct3 and forwarded operands. For the duration of an operation it raises a combinational stall to the hazard unit, which holds the fetch/decode registers and the decode/execute register. Its result is muxed into the execute result path ahead of the execute/memory register.

## Interface
Parameters:
- DATA_WIDTH, 32, operand/result width (only 32 supported)
- CNT_WIDTH, 5, iteration counter width, equal to $clog2(DATA_WIDTH)

Ports:
- clk  input  1  clock
- rst  input  1  synchronous, active-high reset
- flush  input  1  active-high; aborts the operation in flight
- valid_e  input  1  the execute-stage instruction is valid
- mul_sel_e  input  1  the execute-stage instruction is M-extension
- funct3_e  input  3  instr_e[14:12]; selects the op
- op_a  input  DATA_WIDTH  forwarded rs1 value
- op_b  input  DATA_WIDTH  forwarded rs2 value
- busy  output  1  combinational stall request to the hazard unit
- result  output  DATA_WIDTH  final result; valid while result_valid
- result_valid  output  1  result is ready this cycle

## Operation
- Clock and reset: one clock; reset is synchronous and active-high.
- Ops by funct3:
  - 000 MUL: low 32 bits of the product
  - 001 MULH: high 32 bits, signed x signed
  - 010 MULHSU: high 32 bits, signed x unsigned
  - 011 MULHU: high 32 bits, unsigned x unsigned
  - 100 DIV, 101 DIVU: quotient
  - 110 REM, 111 REMU: remainder
- start = valid_e & mul_sel_e & (state==IDLE) & ~flush.
- States:
  - IDLE -> BUSY on start. Operands are latched as magnitudes, with the result sign recorded.
  - IDLE -> DONE on a divide fast-path case.
  - BUSY -> DONE when the counter reaches 31.
  - DONE -> IDLE unconditionally.
  - Any state -> IDLE on flush.
- Multiply: radix-2 shift-add into a 64-bit accumulator, one partial product per cycle, 32 cycles.
- Divide: restoring division, one quotient bit per cycle, 32 cycles. Quotient and remainder registers are 32 bits each; the trial subtract is 33 bits.
- Signs:
  - Signed operands are converted to magnitudes on entry.
  - The product is negated (64-bit two's complement) if the operand signs differ.
  - The quotient is negated if the signs differ.
  - The remainder takes the dividend's sign.
- Fast paths, no iteration:
  - Divide by zero: quotient = 0xFFFFFFFF, remainder = dividend.
  - Signed overflow (0x80000000 / 0xFFFFFFFF): quotient = 0x80000000, remainder = 0.
- In DONE, the still-present start condition for the same instruction is ignored. The return to IDLE happens on the same edge at which the pipeline advances.

## Timing
- Reset values: state IDLE, counter 0, accumulators 0, result 0, result_valid 0, busy 0.
- busy = (start | state==BUSY) & ~flush. It is combinational and low in DONE.
- Normal op, start seen in IDLE at cycle T:
  - busy high for cycles T..T+32 (33 cycles).
  - DONE at T+33 with result_valid=1 and busy=0.
  - The pipeline advances at the end of T+33.
- Fast path: busy high at T only; DONE at T+1.
- result is registered and stable throughout DONE. result_valid is high for exactly one cycle per op.
- flush at any cycle:
  - busy is low in that same cycle.
  - state is IDLE at the next edge.
  - result_valid is never raised for the aborted op.
  - flush overrides a simultaneous start.
- rst takes priority over flush and start.
- Back-to-back M ops: the second start is seen in the IDLE cycle after DONE, so there is no overlap.
- valid_e low or mul_sel_e low in IDLE: no action, busy 0.

## Structure
- Shared package muldiv_pkg holds:
  - the funct3 op encodings as an enum (MUL..REMU)
  - the state enum (IDLE, BUSY, DONE)
  - the constants DIV0_QUOT = 32'hFFFFFFFF and INT_MIN = 32'h80000000
- Sign handling and the final result mux stay inline.
- One sub-module is natural: muldiv_datapath, holding the shift-add and restoring-divide registers plus the counter, driven by a start/step/finish from the FSM.

## Test plan
- MUL 7 x 0xFFFFFFFD, start at T:
  - busy high T..T+32
  - result = 0xFFFFFFEB, result_valid at T+33 only
- MULH 0x80000000 x 0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD. REM on the same operands -> 0xFFFFFFFF. DIVU 100 / 7 -> 14. REMU 100 / 7 -> 2.
- Fast paths:
  - DIVU 5 / 0 -> 0xFFFFFFFF; REMU 5 / 0 -> 5.
  - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM on the same operands -> 0.
  - Each has busy for 1 cycle and result_valid at T+1.
- flush at T+10 of a DIV:
  - busy low at T+10, IDLE at T+11, no result_valid.
  - A following MUL 3 x 4 returns 12 at its start+33.
- rst asserted mid-BUSY: the next cycle has busy=0, result_valid=0, result=0. A subsequent op completes with the normal latency.
